// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of the two-port memory arbiter.
// The slave modport is the arbiter; the master modport is its environment.
interface mem_port_arbiter_if #(
  parameter int CNT_W = 16
);
  logic             i_req;
  logic [31:0]      i_addr;
  logic             i_done;
  logic             i_err;
  logic [31:0]      i_rdata;
  logic             d_req;
  logic [31:0]      d_addr;
  logic [31:0]      d_wdata;
  logic             d_we;
  logic             d_done;
  logic             d_err;
  logic [31:0]      d_rdata;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_wdata;
  logic             mem_read;
  logic             mem_write;
  logic [31:0]      mem_rdata;
  logic             busy;
  logic [CNT_W-1:0] i_cnt;
  logic [CNT_W-1:0] d_cnt;

  modport slave (
    input  i_req, i_addr, d_req, d_addr, d_wdata, d_we, mem_rdata,
    output i_done, i_err, i_rdata, d_done, d_err, d_rdata,
           mem_addr, mem_wdata, mem_read, mem_write, busy, i_cnt, d_cnt
  );

  modport master (
    output i_req, i_addr, d_req, d_addr, d_wdata, d_we, mem_rdata,
    input  i_done, i_err, i_rdata, d_done, d_err, d_rdata,
           mem_addr, mem_wdata, mem_read, mem_write, busy, i_cnt, d_cnt
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between fetch (I) and data (D).
// state  | meaning
// IDLE   | sample requests, grant, latch winner, check address
// ACCESS | drive memory strobe for one cycle, capture read data
// RESP   | pulse winner's done (and err), bump its counter if clean
module mem_port_arbiter #(
  parameter logic [31:0] CAPACITY = 32'h0000_ffff,
  parameter int          CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_port_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             last_gnt;   // 0 = I, 1 = D
  logic             gnt_q;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic             we_q;
  logic             err_q;
  logic [31:0]      i_rdata_q;
  logic [31:0]      d_rdata_q;
  logic [CNT_W-1:0] i_cnt_q;
  logic [CNT_W-1:0] d_cnt_q;

  logic             any_req;
  logic             pick_d;
  logic [31:0]      sel_addr;
  logic             sel_we;
  logic             sel_legal;

  always_comb begin
    state_nxt = state;
    any_req   = bus.i_req | bus.d_req;
    // D wins a tie unless it was the last port served
    pick_d    = bus.d_req & (~bus.i_req | ~last_gnt);
    sel_addr  = pick_d ? bus.d_addr : bus.i_addr;
    sel_we    = pick_d & bus.d_we;
    sel_legal = (sel_addr[1:0] == 2'b00) && (sel_addr <= CAPACITY);
    case (state)
      IDLE:    if (any_req) state_nxt = sel_legal ? ACCESS : RESP;
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      last_gnt  <= 1'b0;
      gnt_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      i_cnt_q   <= '0;
      d_cnt_q   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (any_req) begin
            gnt_q    <= pick_d;
            last_gnt <= pick_d;
            addr_q   <= sel_addr;
            we_q     <= sel_we;
            err_q    <= ~sel_legal;
            if (pick_d) wdata_q <= bus.d_wdata;
          end
        end
        ACCESS: begin
          if (!we_q) begin
            if (gnt_q) d_rdata_q <= bus.mem_rdata;
            else       i_rdata_q <= bus.mem_rdata;
          end
        end
        RESP: begin
          if (!err_q) begin
            if (gnt_q) d_cnt_q <= d_cnt_q + CNT_W'(1);
            else       i_cnt_q <= i_cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Strobes and done are gated by rst_n so a reset cycle never commits or completes
  assign bus.mem_read  = (state == ACCESS) & ~we_q & rst_n;
  assign bus.mem_write = (state == ACCESS) &  we_q & rst_n;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.i_done    = (state == RESP) & ~gnt_q & rst_n;
  assign bus.d_done    = (state == RESP) &  gnt_q & rst_n;
  assign bus.i_err     = bus.i_done & err_q;
  assign bus.d_err     = bus.d_done & err_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.busy      = (state != IDLE);
  assign bus.i_cnt     = i_cnt_q;
  assign bus.d_cnt     = d_cnt_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: behavioural memory, reference memory and
// a queue of expected completions compared as each done pulse appears.
module tb_mem_port_arbiter;

  localparam logic [31:0] CAP = 32'h0000_ffff;

  typedef struct {
    bit          port;   // 0 = I, 1 = D
    bit          err;
    logic [31:0] rdata;
  } exp_t;

  logic clk;
  logic rst_n;

  mem_port_arbiter_if #(.CNT_W(16)) bus ();

  mem_port_arbiter #(.CAPACITY(CAP), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [31:0] mem     [256] = '{default: 32'h0};
  logic [31:0] ref_mem [256] = '{default: 32'h0};
  logic        pl_en;
  logic [7:0]  pl_idx;
  logic [31:0] pl_data;

  always @(posedge clk) begin
    if (pl_en)              mem[pl_idx] <= pl_data;
    else if (bus.mem_write) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
  end

  assign bus.mem_rdata = mem[bus.mem_addr[9:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_assert = 0;
  int          n_fail   = 0;
  exp_t        sb [$];
  logic [31:0] m_rdata [2];
  logic [15:0] m_icnt;
  logic [15:0] m_dcnt;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic sb_check();
    exp_t e;
    logic op;
    n_assert++;
    assert (sb.size() > 0) else begin
      n_fail++;
      $error("FAIL sb_underflow: observed depth 0 expected at least 1");
    end
    if (sb.size() > 0) begin
      e  = sb.pop_front();
      op = bus.d_done;
      chk1("sb_port", op, e.port);
      chk1("sb_err", op ? bus.d_err : bus.i_err, e.err);
      chk32("sb_rdata", op ? bus.d_rdata : bus.i_rdata, e.rdata);
    end
  endtask

  task automatic check_cleared(input string tag);
    chk1({tag, "_busy"}, bus.busy, 1'b0);
    chk1({tag, "_mem_read"}, bus.mem_read, 1'b0);
    chk1({tag, "_mem_write"}, bus.mem_write, 1'b0);
    chk1({tag, "_i_done"}, bus.i_done, 1'b0);
    chk1({tag, "_d_done"}, bus.d_done, 1'b0);
    chk1({tag, "_i_err"}, bus.i_err, 1'b0);
    chk1({tag, "_d_err"}, bus.d_err, 1'b0);
    chk32({tag, "_i_rdata"}, bus.i_rdata, 32'h0);
    chk32({tag, "_d_rdata"}, bus.d_rdata, 32'h0);
    chk32({tag, "_mem_addr"}, bus.mem_addr, 32'h0);
    chk32({tag, "_mem_wdata"}, bus.mem_wdata, 32'h0);
    chk32({tag, "_i_cnt"}, 32'(bus.i_cnt), 32'h0);
    chk32({tag, "_d_cnt"}, 32'(bus.d_cnt), 32'h0);
  endtask

  // One complete transaction from an idle negedge; ends on the idle negedge after done.
  task automatic txn(input bit port, input logic [31:0] addr, input logic [31:0] wdata,
                     input bit we);
    exp_t e;
    bit   legal;
    bit   seen;
    int   lat;
    int   nrd;
    int   nwr;
    legal = (addr[1:0] == 2'b00) && (addr <= CAP);
    if (legal && !we) m_rdata[port] = ref_mem[addr[9:2]];
    if (legal && we)  ref_mem[addr[9:2]] = wdata;
    e.port  = port;
    e.err   = !legal;
    e.rdata = m_rdata[port];
    sb.push_back(e);
    if (port) begin
      bus.d_req   = 1'b1;
      bus.d_addr  = addr;
      bus.d_wdata = wdata;
      bus.d_we    = we;
    end else begin
      bus.i_req  = 1'b1;
      bus.i_addr = addr;
    end
    seen = 1'b0;
    lat  = 0;
    nrd  = 0;
    nwr  = 0;
    for (int k = 1; k <= 4 && !seen; k++) begin
      @(negedge clk);
      if (bus.mem_read)  nrd++;
      if (bus.mem_write) nwr++;
      if (bus.mem_read || bus.mem_write) chk32("mem_addr", bus.mem_addr, addr);
      if (bus.mem_write) chk32("mem_wdata", bus.mem_wdata, wdata);
      if (port ? bus.d_done : bus.i_done) begin
        seen = 1'b1;
        lat  = k;
      end
    end
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    chk1("done_seen", seen, 1'b1);
    if (seen) begin
      sb_check();
      chk32("latency", 32'(lat), legal ? 32'd2 : 32'd1);
      chk32("rd_strobes", 32'(nrd), (legal && !we) ? 32'd1 : 32'd0);
      chk32("wr_strobes", 32'(nwr), (legal && we) ? 32'd1 : 32'd0);
    end
    if (legal) begin
      if (port) m_dcnt = m_dcnt + 16'd1;
      else      m_icnt = m_icnt + 16'd1;
    end
    @(negedge clk);
    chk1("busy_after", bus.busy, 1'b0);
    chk32("i_cnt", 32'(bus.i_cnt), 32'(m_icnt));
    chk32("d_cnt", 32'(bus.d_cnt), 32'(m_dcnt));
  endtask

  task automatic model_reset();
    m_rdata[0] = 32'h0;
    m_rdata[1] = 32'h0;
    m_icnt     = 16'h0;
    m_dcnt     = 16'h0;
  endtask

  initial begin
    exp_t e;
    model_reset();
    rst_n       = 1'b0;
    bus.i_req   = 1'b1;
    bus.d_req   = 1'b1;
    bus.i_addr  = 32'h0;
    bus.d_addr  = 32'h0;
    bus.d_wdata = 32'h0;
    bus.d_we    = 1'b0;
    pl_en       = 1'b1;
    pl_idx      = 8'h0a;   // byte address 0x28
    pl_data     = 32'h0050_0093;
    ref_mem[8'h0a] = 32'h0050_0093;

    // Reset held for two cycles with both requests high
    @(negedge clk);
    check_cleared("rst1");
    pl_en = 1'b0;
    @(negedge clk);
    check_cleared("rst2");
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    rst_n     = 1'b1;
    @(negedge clk);
    chk1("idle_busy", bus.busy, 1'b0);

    // Fetch, store, load, boundary and rejected accesses
    txn(1'b0, 32'h0000_0028, 32'h0, 1'b0);
    txn(1'b1, 32'h0000_0040, 32'hdead_beef, 1'b1);
    txn(1'b1, 32'h0000_0040, 32'h0, 1'b0);
    txn(1'b1, 32'h0000_0042, 32'h1111_2222, 1'b1);
    txn(1'b1, 32'h0001_0000, 32'h0, 1'b0);
    txn(1'b1, 32'h0000_fffc, 32'hcafe_f00d, 1'b1);
    txn(1'b1, 32'h0000_fffc, 32'h0, 1'b0);
    txn(1'b0, 32'h0000_002a, 32'h0, 1'b0);
    txn(1'b0, 32'h0000_fffc, 32'h0, 1'b0);

    // Both ports requesting continuously from reset: D, then I, then D
    rst_n     = 1'b0;
    bus.i_req = 1'b1;
    bus.d_req = 1'b1;
    bus.i_addr = 32'h0000_0028;
    bus.d_addr = 32'h0000_0040;
    bus.d_we   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_cleared("rst_both");
    rst_n = 1'b1;
    model_reset();
    e.err = 1'b0;
    e.port = 1'b1; e.rdata = ref_mem[8'h10]; sb.push_back(e);
    e.port = 1'b0; e.rdata = ref_mem[8'h0a]; sb.push_back(e);
    e.port = 1'b1; e.rdata = ref_mem[8'h10]; sb.push_back(e);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      chk1($sformatf("rr_i_done_c%0d", c), bus.i_done, c == 5);
      chk1($sformatf("rr_d_done_c%0d", c), bus.d_done, c == 2 || c == 8);
      if (bus.i_done || bus.d_done) sb_check();
      if (c == 8) begin
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
      end
    end
    m_icnt = 16'd1;
    m_dcnt = 16'd2;
    m_rdata[0] = ref_mem[8'h0a];
    m_rdata[1] = ref_mem[8'h10];
    chk32("rr_i_cnt", 32'(bus.i_cnt), 32'(m_icnt));
    chk32("rr_d_cnt", 32'(bus.d_cnt), 32'(m_dcnt));

    // Reset asserted during the ACCESS cycle of a store
    bus.d_req   = 1'b1;
    bus.d_addr  = 32'h0000_0080;
    bus.d_wdata = 32'h1234_5678;
    bus.d_we    = 1'b1;
    @(negedge clk);
    chk1("abort_write_pre", bus.mem_write, 1'b1);
    rst_n     = 1'b0;
    bus.d_req = 1'b0;
    #1;
    chk1("abort_write_gated", bus.mem_write, 1'b0);
    chk1("abort_no_done", bus.d_done, 1'b0);
    @(negedge clk);
    chk1("abort_busy", bus.busy, 1'b0);
    chk1("abort_d_done", bus.d_done, 1'b0);
    chk32("abort_mem_kept", mem[8'h20], ref_mem[8'h20]);
    chk32("abort_d_cnt", 32'(bus.d_cnt), 32'h0);
    chk32("abort_i_cnt", 32'(bus.i_cnt), 32'h0);
    chk32("abort_d_rdata", bus.d_rdata, 32'h0);
    chk32("abort_i_rdata", bus.i_rdata, 32'h0);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);

    txn(1'b0, 32'h0000_0028, 32'h0, 1'b0);
    txn(1'b1, 32'h0000_0080, 32'h0, 1'b0);

    chk32("sb_leftover", 32'(sb.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
